// File: rtl/muldiv_unit.sv
// muldiv_unit: E-stage multiply/divide unit with HI/LO registers.
// Ports: clk, reset (async, active-high), start, op[2:0], src_a, src_b,
//   cancel, hilo_wr[1:0] (mthi/mtlo) -> busy, hi, lo.
//   op: 000 mult,001 multu,010 div,011 divu,100 madd,101 maddu,
//       110 msub,111 msubu. Stall the pipe on busy | start.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic [1:0]       hilo_wr,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W2   = 2 * WIDTH;
  localparam int MAXL =
    (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [2:0]       op_q, op_n;
  logic [W2-1:0]    pend, pend_n;
  logic             busy_n;
  logic [WIDTH-1:0] hi_n, lo_n;

  // operand decode for the incoming op
  logic             sgn;
  logic             is_div;
  logic             a_neg, b_neg;
  logic [W2-1:0]    ea, eb, prod_c;
  logic [WIDTH-1:0] abs_a, abs_b, dvs;
  logic [WIDTH-1:0] q, r, quot, rem;
  logic [W2-1:0]    div_c, res_c;

  assign sgn    = ~op[0];
  assign is_div = ~op[2] & op[1];
  assign a_neg  = sgn & src_a[WIDTH-1];
  assign b_neg  = sgn & src_b[WIDTH-1];

  // sign-extend to 2W so the low 2W bits of
  // an unsigned multiply are the signed product
  assign ea     = {{WIDTH{a_neg}}, src_a};
  assign eb     = {{WIDTH{b_neg}}, src_b};
  assign prod_c = ea * eb;

  // magnitude divide, then restore signs; MIN/-1
  // falls out as quot=MIN, rem=0
  assign abs_a = a_neg ? -src_a : src_a;
  assign abs_b = b_neg ? -src_b : src_b;
  assign dvs   = (src_b == '0) ? WIDTH'(1) : abs_b;
  assign q     = abs_a / dvs;
  assign r     = abs_a % dvs;
  assign quot  = (a_neg ^ b_neg) ? -q : q;
  assign rem   = a_neg ? -r : r;

  assign div_c = (src_b == '0)
               ? {src_a, {WIDTH{1'b1}}}
               : {rem, quot};
  assign res_c = is_div ? div_c : prod_c;

  // completion value: plain result or accumulate
  logic [W2-1:0] acc, wr_val;

  assign acc = {hi, lo};

  always_comb begin
    wr_val = pend;
    unique case (1'b1)
      ~op_q[2]:          wr_val = pend;
      op_q[2] & op_q[1]: wr_val = acc - pend;
      op_q[2] & ~op_q[1]: wr_val = acc + pend;
      default:           wr_val = pend;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      pend  <= '0;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      op_q  <= op_n;
      pend  <= pend_n;
      busy  <= busy_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    pend_n  = pend;
    busy_n  = busy;
    hi_n    = hi;
    lo_n    = lo;
    unique case (state)
      IDLE: begin
        if (hilo_wr != 2'b00) begin
          if (hilo_wr[1]) hi_n = src_a;
          if (hilo_wr[0]) lo_n = src_a;
        end else if (start & ~cancel) begin
          state_n = BUSY;
          busy_n  = 1'b1;
          op_n    = op;
          pend_n  = res_c;
          cnt_n   = is_div ? CW'(DIV_LAT)
                           : CW'(MUL_LAT);
        end
      end
      BUSY: begin
        if (cancel) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = '0;
        end else if (cnt == CW'(1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          cnt_n   = '0;
          hi_n    = wr_val[W2-1:WIDTH];
          lo_n    = wr_val[WIDTH-1:0];
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit
// (latency, arithmetic, HI/LO writes, cancel, reset).
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         cancel;
  logic [1:0]   hilo_wr;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_unit #(
    .WIDTH  (W),
    .MUL_LAT(5),
    .DIV_LAT(10)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .hilo_wr(hilo_wr),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [2:0] o,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b);
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag,
                           input int lat);
    int c;
    c = 0;
    while (busy === 1'b1 && c < 40) begin
      c++;
      @(negedge clk);
    end
    chk(tag, W'(c), W'(lat));
  endtask

  task automatic run(input string tag,
                     input logic [2:0] o,
                     input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input int lat,
                     input logic [W-1:0] ehi,
                     input logic [W-1:0] elo);
    launch(o, a, b);
    wait_done({tag, ".lat"}, lat);
    chk({tag, ".hi"}, hi, ehi);
    chk({tag, ".lo"}, lo, elo);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    cancel  = 1'b0;
    op      = 3'b000;
    src_a   = '0;
    src_b   = '0;
    hilo_wr = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.hi", hi, 32'h0);
    chk("rst.lo", lo, 32'h0);

    run("multu", 3'b001, 32'hFFFFFFFF, 32'h2,
        5, 32'h00000001, 32'hFFFFFFFE);
    run("mult", 3'b000, 32'hFFFFFFFD, 32'h7,
        5, 32'hFFFFFFFF, 32'hFFFFFFEB);
    run("div", 3'b010, 32'hFFFFFFF9, 32'h2,
        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu0", 3'b011, 32'h7, 32'h0,
        10, 32'h00000007, 32'hFFFFFFFF);
    run("divmin", 3'b010, 32'h80000000,
        32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
    run("div0", 3'b010, 32'hFFFFFFF9, 32'h0,
        10, 32'hFFFFFFF9, 32'hFFFFFFFF);

    src_a   = 32'h1;
    hilo_wr = 2'b10;
    @(negedge clk);
    src_a   = 32'hFFFFFFFF;
    hilo_wr = 2'b01;
    @(negedge clk);
    hilo_wr = 2'b00;
    chk("mthi", hi, 32'h1);
    chk("mtlo", lo, 32'hFFFFFFFF);

    run("maddu", 3'b101, 32'h1, 32'h1,
        5, 32'h2, 32'h0);
    run("msub", 3'b110, 32'h1, 32'h1,
        5, 32'h1, 32'hFFFFFFFF);
    run("madd", 3'b100, 32'hFFFFFFFF, 32'h1,
        5, 32'h1, 32'hFFFFFFFE);
    run("msubu", 3'b111, 32'hFFFFFFFF,
        32'hFFFFFFFF, 5, 32'h3, 32'hFFFFFFFD);

    // start while busy must not disturb the op
    launch(3'b000, 32'h2, 32'h3);
    op    = 3'b011;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("sbusy.lat", 4);
    chk("sbusy.hi", hi, 32'h0);
    chk("sbusy.lo", lo, 32'h6);

    // cancel mid-divide
    launch(3'b011, 32'd100, 32'd3);
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cncl.busy", {31'd0, busy}, 32'd0);
    chk("cncl.hi", hi, 32'h0);
    chk("cncl.lo", lo, 32'h6);
    repeat (12) @(negedge clk);
    chk("cncl.late.lo", lo, 32'h6);

    // start and cancel together
    op     = 3'b011;
    src_a  = 32'd9;
    src_b  = 32'd3;
    start  = 1'b1;
    cancel = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    cancel = 1'b0;
    chk("sc.busy", {31'd0, busy}, 32'd0);
    repeat (12) @(negedge clk);
    chk("sc.busy2", {31'd0, busy}, 32'd0);
    chk("sc.lo", lo, 32'h6);

    // async reset between edges mid-divide
    launch(3'b010, 32'd50, 32'd7);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst.busy", {31'd0, busy}, 32'd0);
    chk("arst.hi", hi, 32'h0);
    chk("arst.lo", lo, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // mtlo wins over start
    op      = 3'b000;
    src_a   = 32'h12345678;
    src_b   = 32'h2;
    start   = 1'b1;
    hilo_wr = 2'b01;
    @(negedge clk);
    start   = 1'b0;
    hilo_wr = 2'b00;
    chk("wrs.lo", lo, 32'h12345678);
    chk("wrs.hi", hi, 32'h0);
    chk("wrs.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("wrs.busy2", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
